// File: rtl/btb_and_pc_if.sv
// Fetch-stage bundle between the PC/BTB block and the pipeline around it.
// master: pipeline side (drives control/addresses), slave: btb_and_pc.
interface btb_and_pc_if;
    logic        PC_enable;
    logic        takeBranch;
    logic        incorrect_b_prediction;
    logic [31:0] PC_plus_4;
    logic [31:0] instruction_IFID_in;
    logic [31:0] branch_PC;
    logic [31:0] PC_IFID_IDEX;
    logic [31:0] PC_plus4_IFID_out;
    logic [31:0] PC_IFID_in;

    modport master (
        output PC_enable,
        output takeBranch,
        output incorrect_b_prediction,
        output PC_plus_4,
        output instruction_IFID_in,
        output branch_PC,
        output PC_IFID_IDEX,
        output PC_plus4_IFID_out,
        input  PC_IFID_in
    );

    modport slave (
        input  PC_enable,
        input  takeBranch,
        input  incorrect_b_prediction,
        input  PC_plus_4,
        input  instruction_IFID_in,
        input  branch_PC,
        input  PC_IFID_IDEX,
        input  PC_plus4_IFID_out,
        output PC_IFID_in
    );
endinterface

// File: rtl/btb_and_pc.sv
// Fetch PC register plus direct-mapped BTB with 2-bit counters.
// Ports: clk, rst_n (async active-low), bus (btb_and_pc_if.slave).
module btb_and_pc #(
    parameter int ENTRIES = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    btb_and_pc_if.slave bus
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]        pc_q, pc_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q [ENTRIES];
    logic [TW-1:0]      tag_d [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [31:0]        tgt_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];

    // Lookup side, indexed by the current fetch PC.
    logic [IDX-1:0] rd_idx;
    logic [TW-1:0]  rd_tag;
    logic           rd_hit;
    logic           is_cti;
    logic           predict;

    assign rd_idx  = pc_q[IDX+1:2];
    assign rd_tag  = pc_q[31:IDX+2];
    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    // Only trust a hit when the fetched word really is a branch/JAL,
    // so aliasing onto ordinary instructions never redirects fetch.
    assign is_cti  = (bus.instruction_IFID_in[6:0] == OP_BRANCH) ||
                     (bus.instruction_IFID_in[6:0] == OP_JAL);
    assign predict = rd_hit && ctr_q[rd_idx][1] && is_cti;

    // Update side, indexed by the decode-stage instruction's PC.
    logic [IDX-1:0] wr_idx;
    logic [TW-1:0]  wr_tag;
    logic           wr_hit;

    assign wr_idx = bus.PC_IFID_IDEX[IDX+1:2];
    assign wr_tag = bus.PC_IFID_IDEX[31:IDX+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    logic [31:0] next_pc;

    always_comb begin
        next_pc = bus.PC_plus_4;
        if (bus.incorrect_b_prediction && bus.takeBranch) begin
            next_pc = bus.branch_PC;
        end else if (bus.incorrect_b_prediction) begin
            next_pc = bus.PC_plus4_IFID_out;
        end else if (predict) begin
            next_pc = tgt_q[rd_idx];
        end
        pc_d = bus.PC_enable ? next_pc : pc_q;
    end

    // Training runs every cycle regardless of stalls.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (bus.takeBranch) begin
            if (wr_hit) begin
                tgt_d[wr_idx] = bus.branch_PC;
                if (ctr_q[wr_idx] != 2'b11) begin
                    ctr_d[wr_idx] = ctr_q[wr_idx] + 2'd1;
                end
            end else begin
                valid_d[wr_idx] = 1'b1;
                tag_d[wr_idx]   = wr_tag;
                tgt_d[wr_idx]   = bus.branch_PC;
                ctr_d[wr_idx]   = 2'b10;
            end
        end else if (bus.incorrect_b_prediction && wr_hit) begin
            if (ctr_q[wr_idx] != 2'b00) begin
                ctr_d[wr_idx] = ctr_q[wr_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'h0000_0000;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        ctr_q <= ctr_d;
    end

    assign bus.PC_IFID_in = pc_q;
endmodule

// File: tb/tb_btb_and_pc.sv
// Scoreboard bench for btb_and_pc: directed scenarios then random traffic
// checked against a behavioural BTB/PC model.
module tb_btb_and_pc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    btb_and_pc_if bus ();

    btb_and_pc #(.ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    int          id_q  [$];
    int          nstep = 0;

    // Behavioural model
    logic [31:0] mpc;
    bit          mv   [16];
    logic [31:0] mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];

    localparam logic [6:0] OPB = 7'h63;
    localparam logic [6:0] OPJ = 7'h6F;
    localparam logic [6:0] OPA = 7'h13;

    task automatic model_reset();
        mpc = 32'h0;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic idle();
        bus.PC_enable = 1'b0;
        bus.takeBranch = 1'b0;
        bus.incorrect_b_prediction = 1'b0;
        bus.PC_plus_4 = 32'h0;
        bus.instruction_IFID_in = 32'h13;
        bus.branch_PC = 32'h0;
        bus.PC_IFID_IDEX = 32'h0;
        bus.PC_plus4_IFID_out = 32'h0;
    endtask

    task automatic step(input bit en, input bit tbr, input bit inc,
                        input logic [31:0] bpc, input logic [31:0] idex,
                        input logic [31:0] p4o, input logic [6:0] op,
                        input bit chk, input logic [31:0] want);
        logic [31:0] ins;
        logic [31:0] nxt;
        logic [31:0] e;
        int          i;
        int          w;
        bit          hit;
        bit          pred;
        @(negedge clk);
        ins = $urandom();
        ins[6:0] = op;
        bus.PC_enable = en;
        bus.takeBranch = tbr;
        bus.incorrect_b_prediction = inc;
        bus.PC_plus_4 = mpc + 32'd4;
        bus.instruction_IFID_in = ins;
        bus.branch_PC = bpc;
        bus.PC_IFID_IDEX = idex;
        bus.PC_plus4_IFID_out = p4o;
        // Prediction uses the table before this cycle's training.
        i = int'((mpc >> 2) % 16);
        hit = mv[i] && (mtag[i] == (mpc >> 6));
        pred = hit && (mctr[i] >= 2) && (op == OPB || op == OPJ);
        if (inc) nxt = tbr ? bpc : p4o;
        else if (pred) nxt = mtgt[i];
        else nxt = mpc + 32'd4;
        e = en ? nxt : mpc;
        exp_q.push_back(chk ? want : e);
        id_q.push_back(nstep);
        nstep++;
        w = int'((idex >> 2) % 16);
        hit = mv[w] && (mtag[w] == (idex >> 6));
        if (tbr) begin
            if (hit) begin
                mtgt[w] = bpc;
                if (mctr[w] < 3) mctr[w]++;
            end else begin
                mv[w] = 1'b1;
                mtag[w] = idex >> 6;
                mtgt[w] = bpc;
                mctr[w] = 2;
            end
        end else if (inc && hit) begin
            if (mctr[w] > 0) mctr[w]--;
        end
        mpc = e;
    endtask

    // Redirect fetch to addr via an update address that never hits.
    task automatic go(input logic [31:0] addr);
        step(1, 0, 1, 32'h0, 32'h300, addr, OPA, 1, addr);
    endtask

    // Monitor: one PC observation per clock once stimulus is queued.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                logic [31:0] want;
                int          id;
                want = exp_q.pop_front();
                id = id_q.pop_front();
                checks++;
                if (bus.PC_IFID_in !== want) begin
                    failures++;
                    $display("FAIL pc_step%0d got=%h want=%h",
                             id, bus.PC_IFID_in, want);
                end
            end
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] s [6];
        s[0] = 32'h10; s[1] = 32'h50; s[2] = 32'h20;
        s[3] = 32'h60; s[4] = 32'h24; s[5] = 32'h90;
        return s[$urandom_range(5)];
    endfunction

    initial begin
        idle();
        model_reset();
        #2;
        checks++;
        if (bus.PC_IFID_in !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc got=%h want=0", bus.PC_IFID_in);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 0, 0, 0, 32'h300, 0, OPA, 1, 32'h4);
        step(1, 0, 0, 0, 32'h300, 0, OPA, 1, 32'h8);
        step(1, 0, 0, 0, 32'h300, 0, OPA, 1, 32'hC);
        step(0, 0, 0, 0, 32'h300, 0, OPA, 1, 32'hC);
        step(0, 0, 0, 0, 32'h300, 0, OPA, 1, 32'hC);
        // First JAL at 0x10 -> 0x40: redirect and allocate.
        step(1, 1, 1, 32'h40, 32'h10, 0, OPA, 1, 32'h40);
        go(32'h10);
        step(1, 0, 0, 0, 32'h300, 0, OPA, 1, 32'h14);
        go(32'h10);
        step(1, 0, 0, 0, 32'h300, 0, OPJ, 1, 32'h40);
        // Mispredicted: counter 2 -> 1.
        step(1, 0, 1, 0, 32'h10, 32'h14, OPA, 1, 32'h14);
        go(32'h10);
        step(1, 0, 0, 0, 32'h300, 0, OPB, 1, 32'h14);
        // Retrain 1 -> 2.
        step(1, 1, 1, 32'h40, 32'h10, 0, OPA, 1, 32'h40);
        go(32'h10);
        step(1, 0, 0, 0, 32'h300, 0, OPJ, 1, 32'h40);
        // Alias 0x50 shares the index of 0x10.
        go(32'h50);
        step(1, 0, 0, 0, 32'h300, 0, OPB, 1, 32'h54);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.PC_IFID_in !== 32'h0) begin
            failures++;
            $display("FAIL midreset_pc got=%h want=0", bus.PC_IFID_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        go(32'h10);
        step(1, 0, 0, 0, 32'h300, 0, OPJ, 1, 32'h14);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [6:0]  op;
            bit          en;
            bit          inc;
            bit          tbr;
            a = pick();
            case ($urandom_range(2))
                0: op = OPB;
                1: op = OPJ;
                default: op = OPA;
            endcase
            en = ($urandom_range(99) < 85);
            inc = ($urandom_range(99) < 30);
            tbr = ($urandom_range(99) < 40);
            step(en, tbr, inc, pick(), a, a + 32'd4, op, 0, 32'h0);
        end

        @(negedge clk);
        idle();
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btb_and_pc.md
# btb_and_pc

Program-counter register and direct-mapped branch target buffer (BTB) for the fetch stage of the 5-stage RV32 pipeline. It holds the current fetch address (`PC_IFID_in`) and selects each next PC. Candidates are sequential PC+4, a BTB-predicted target, a resolved branch target, or the fall-through of a mispredicted branch. Branches resolve in decode, and the block learns from those resolutions using 2-bit saturating counters.

## Interface
- `ENTRIES`, 16: number of BTB entries (power of two); index = `PC[IDX+1:2]`, tag = `PC[31:IDX+2]`, IDX = log2(ENTRIES).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `PC_enable`  in  1  1 = PC register may load next PC; 0 = hold (stall).
- `takeBranch`  in  1  decode-stage instruction at `PC_IFID_IDEX` resolved taken (branch or JAL).
- `PC_plus_4`  in  32  current PC + 4, computed externally.
- `instruction_IFID_in`  in  32  instruction fetched at current PC; valid before the next rising edge.
- `branch_PC`  in  32  resolved target of the decode-stage instruction.
- `incorrect_b_prediction`  in  1  decode-stage prediction was wrong; redirect required.
- `PC_IFID_IDEX`  in  32  PC of the decode-stage instruction (BTB update address).
- `PC_plus4_IFID_out`  in  32  PC+4 of the decode-stage instruction (fall-through).
- `PC_IFID_in`  out  32  current fetch PC (registered).

## Operation
- BTB entry fields: valid, tag, 32-bit target, 2-bit counter.
- Lookup uses the current `PC_IFID_in`, purely combinational.
- Hit: valid and tag match.
- Predict-taken requires all of:
  - a hit;
  - counter[1] = 1;
  - `instruction_IFID_in[6:0]` is 7'b1100011 (branch) or 7'b1101111 (JAL). This filters aliasing onto non-control instructions.
- Next-PC priority:
  1. `incorrect_b_prediction` and `takeBranch` → `branch_PC`.
  2. `incorrect_b_prediction` and not `takeBranch` → `PC_plus4_IFID_out`.
  3. Predict-taken → BTB target.
  4. Otherwise → `PC_plus_4`.
- BTB update is independent of `PC_enable` and uses entry index/tag from `PC_IFID_IDEX`.
  - `takeBranch` = 1, entry hit: write target = `branch_PC`; counter increments, saturating at 3.
  - `takeBranch` = 1, entry miss or invalid: allocate (overwrite). Set valid, tag, target = `branch_PC`, counter = 2'b10.
  - `incorrect_b_prediction` = 1 and `takeBranch` = 0, entry hit: counter decrements, saturating at 0. Entry stays valid.
  - Otherwise no change.
- Arithmetic: counters saturate and never wrap. No PC arithmetic is done internally; all 32-bit addresses pass through unmodified.

## Timing
- Reset: `PC_IFID_in` = 32'h0000_0000; all BTB valid bits = 0. Counters, tags, and targets are don't-care.
- `PC_IFID_in` loads next PC on the rising edge when `PC_enable` = 1. It holds when `PC_enable` = 0, including when a redirect is pending. The upstream logic keeps `incorrect_b_prediction` asserted until the load.
- Latency:
  - Redirect: next PC visible one cycle after `incorrect_b_prediction` is sampled.
  - Prediction: a BTB hit affects the PC loaded at the next edge.
- BTB writes occur on the same rising edge as the PC load. A lookup of the same entry in that cycle sees the old contents (read-before-write).
- Reset asserted mid-operation forces the reset state immediately, regardless of clock.

## Test plan
- Reset, `PC_enable` = 1, no branches, `PC_plus_4` = PC+4 → `PC_IFID_in` steps 0, 4, 8, 12 on successive edges; hold `PC_enable` = 0 → PC stays 12.
- First JAL at PC 0x10, target 0x40:
  - `takeBranch` = 1, `incorrect_b_prediction` = 1, `PC_IFID_IDEX` = 0x10 → next PC = 0x40.
  - BTB entry 4 allocated with counter 2.
- Refetch 0x10 with instruction opcode 1101111 → next PC = 0x40, no redirect. Same PC with opcode 0010011 (ADDI) → next PC = 0x14.
- Predicted branch at 0x10 resolves not taken: `incorrect_b_prediction` = 1, `takeBranch` = 0, `PC_plus4_IFID_out` = 0x14 → next PC = 0x14, counter 2→1; next fetch of 0x10 predicts not taken.
- Alias: PC 0x50 (same index as 0x10, different tag) with branch opcode → miss, next PC = `PC_plus_4`.
- Assert `rst_n` low between clock edges after training → PC = 0 immediately; previously trained 0x10 no longer predicts.
